// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: an operand channel in and a result channel out.
// Both channels use valid/ready. A transfer happens on a rising clk edge where valid && ready.
// The source holds valid and its payload steady until that edge, and ready may depend on state only.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit. Each cycle it adds DIGIT bits, starting at the LSB.
// The carry is held in a register between cycles. The result is held in DONE until the consumer accepts it.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic [1:0]     o_dbg_state
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_a_msb;
  logic             r_b_msb;

  logic [DIGIT:0]   w_digit;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  assign w_digit    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // The new digit enters from the MSB side, so after STEPS shifts the LSB digit is at bit 0.
  assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_digit[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_cnt   <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_next;
          r_carry <= w_digit[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_digit[DIGIT];
            // The operand MSBs are kept separately because r_a/r_b have been shifted away by now.
            r_ovf  <= (r_a_msb == r_b_msb) & (w_sum_next[WIDTH-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;
endmodule
